// File: rtl/mul_div_unit.sv
// HI/LO multiply/divide unit: multi-cycle mult/div/madd/msub with a fixed latency
// counter, plus single-cycle mthi/mtlo writes. Results commit only at the final edge.
module mul_div_unit #(
    parameter int MUL_LATENCY = 5,
    parameter int DIV_LATENCY = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  mulCtrl,
    input  logic        mulEnable,
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    input  logic        mulOutputSel,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] result,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [3:0] MT_MULT   = 4'd1;
    localparam logic [3:0] MT_MULTU  = 4'd2;
    localparam logic [3:0] MT_DIV    = 4'd3;
    localparam logic [3:0] MT_DIVU   = 4'd4;
    localparam logic [3:0] MT_SETHI  = 4'd5;
    localparam logic [3:0] MT_SETLO  = 4'd6;
    localparam logic [3:0] MT_MADD   = 4'd7;
    localparam logic [3:0] MT_MADDU  = 4'd8;
    localparam logic [3:0] MT_MSUB   = 4'd9;

    localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [3:0]         op_reg, op_next;
    logic [31:0]        a_reg, a_next;
    logic [31:0]        b_reg, b_next;
    logic [31:0]        hi_reg, hi_next;
    logic [31:0]        lo_reg, lo_next;

    logic               op_signed;
    logic [63:0]        mul_a, mul_b, product, acc, commit_val;
    logic [31:0]        a_mag, b_mag, den, q_mag, r_mag, quot, rem;

    // Datapath works from latched operands; only its value at the final edge is used.
    always_comb begin
        op_signed = (op_reg == MT_MULT) || (op_reg == MT_DIV) ||
                    (op_reg == MT_MADD) || (op_reg == MT_MSUB);
        mul_a     = op_signed ? {{32{a_reg[31]}}, a_reg} : {32'd0, a_reg};
        mul_b     = op_signed ? {{32{b_reg[31]}}, b_reg} : {32'd0, b_reg};
        product   = mul_a * mul_b;
        acc       = {hi_reg, lo_reg};

        // Signed divide runs on magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
        a_mag = (op_signed && a_reg[31]) ? -a_reg : a_reg;
        b_mag = (op_signed && b_reg[31]) ? -b_reg : b_reg;
        den   = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag = a_mag / den;
        r_mag = a_mag % den;
        quot  = (op_signed && (a_reg[31] ^ b_reg[31])) ? -q_mag : q_mag;
        rem   = (op_signed && a_reg[31]) ? -r_mag : r_mag;

        case (op_reg)
            MT_MADD, MT_MADDU: commit_val = acc + product;
            MT_MSUB:           commit_val = acc - product;
            MT_DIV, MT_DIVU:   commit_val = (b_reg == 32'd0) ? acc : {rem, quot};
            default:           commit_val = product;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;

        case (state_reg)
            ST_IDLE: begin
                if (mulEnable && !flush) begin
                    case (mulCtrl)
                        MT_MULT, MT_MULTU, MT_MADD, MT_MADDU, MT_MSUB: begin
                            state_next = ST_RUN;
                            cnt_next   = CNT_W'(MUL_LATENCY);
                            op_next    = mulCtrl;
                            a_next     = operandA;
                            b_next     = operandB;
                        end
                        MT_DIV, MT_DIVU: begin
                            state_next = ST_RUN;
                            cnt_next   = CNT_W'(DIV_LATENCY);
                            op_next    = mulCtrl;
                            a_next     = operandA;
                            b_next     = operandB;
                        end
                        MT_SETHI: hi_next = operandA;
                        MT_SETLO: lo_next = operandA;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                // Flush beats commit, even on the final cycle.
                if (flush) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg <= CNT_W'(1)) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                    hi_next    = commit_val[63:32];
                    lo_next    = commit_val[31:0];
                end else begin
                    cnt_next   = cnt_reg - CNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
        end
    end

    assign busy   = (state_reg == ST_RUN);
    assign hi     = hi_reg;
    assign lo     = lo_reg;
    assign result = mulOutputSel ? hi_reg : lo_reg;

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter MUL_LATENCY, default 5: cycles from accepting mult/multu/madd/maddu/msub to HI/LO update.
REQ-002 Parameter DIV_LATENCY, default 10: cycles from accepting div/divu to HI/LO update.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 mulCtrl  input  4  operation from the decoder: 0 mtDisabled, 1 mtMultiply, 2 mtMultiplyUnsigned, 3 mtDivide, 4 mtDivideUnsigned, 5 mtSetHI, 6 mtSetLO, 7 mtMADD, 8 mtMADDU, 9 mtMSUB (values fixed in constants.v).
REQ-006 mulEnable  input  1  operation valid this cycle (decoder asserts when mulCtrl != 0).
REQ-007 operandA  input  32  rs value (forwarded).
REQ-008 operandB  input  32  rt value (forwarded).
REQ-009 mulOutputSel  input  1  1 selects HI, 0 selects LO.
REQ-010 flush  input  1  cancel in-flight operation (exception/ERET in younger-than-E stage).
REQ-011 busy  output  1  operation in flight; hazard unit stalls any mul-class or mfhi/mflo instruction in E while high.
REQ-012 result  output  32  HI or LO per mulOutputSel, combinational from architectural registers.
REQ-013 hi, lo  output  32 each  architectural HI/LO registers.

Function
REQ-014 Accept: at edge where mulEnable=1, busy=0, flush=0 and mulCtrl in 1..4 or 7..9; operands and op latched; counter loaded with latency.
REQ-015 Requests with mulEnable=1 while busy=1 SHALL be ignored; no state change.
REQ-016 mtSetHI/mtSetLO: accepted when busy=0 and flush=0; HI (resp. LO) written with operandA at that edge; busy not asserted.
REQ-017 States IDLE and RUN; IDLE->RUN on accept of a multi-cycle op; RUN->IDLE on counter reaching final cycle or flush.
REQ-018 busy = 1 exactly while in RUN: from the cycle after accept edge N through the cycle before edge N+LATENCY.
REQ-019 HI/LO update at edge N+LATENCY, same edge busy falls; new op acceptable at that edge's following cycle.
REQ-020 mult: {HI,LO} = signed(A)*signed(B), 64-bit; multu: unsigned 64-bit product.
REQ-021 madd: {HI,LO} += signed product; maddu: += unsigned product; msub: -= signed product; 64-bit modulo 2^64, {HI,LO} sampled at commit edge.
REQ-022 div: LO = signed quotient truncated toward zero, HI = remainder with sign of dividend; divu: unsigned.
REQ-023 Divide by zero: full DIV_LATENCY busy, HI/LO unchanged at commit.
REQ-024 Signed overflow case 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
REQ-025 flush in RUN: return to IDLE next edge, HI/LO unchanged, busy low next cycle.
REQ-026 flush with simultaneous request: request ignored, including mthi/mtlo.
REQ-027 mulCtrl=0 or values 10..15 with mulEnable=1: no effect, no error.
REQ-028 result valid in any cycle; reflects committed HI/LO only, never partial results.

Reset
REQ-029 reset_n low asynchronously forces IDLE, busy=0, hi=0, lo=0, counter=0, latched operands=0.
REQ-030 reset_n asserted mid-RUN abandons operation; no HI/LO commit after release.
REQ-031 First accept possible at first rising edge with reset_n high.

Verification
REQ-032 mult A=0xFFFFFFFE (-2), B=3 at edge N -> busy high 5 cycles; edge N+5: HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-033 multu A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE; then madd A=1,B=1 -> LO=0xFFFFFFFF, HI=1; msub A=2,B=1 -> LO=0xFFFFFFFD, HI=1.
REQ-034 div A=-7 (0xFFFFFFF9), B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu same operands -> LO=0x7FFFFFFC, HI=1.
REQ-035 div by B=0 with HI=0x1234, LO=0x5678 -> busy 10 cycles, HI/LO remain 0x1234/0x5678.
REQ-036 Start div, assert flush on 3rd busy cycle -> busy low next cycle, HI/LO unchanged; mthi A=0xAAAA during busy ignored, after idle writes HI=0xAAAA.
REQ-037 Start mult, pull reset_n low mid-RUN -> immediately busy=0, hi=lo=0; no later commit.
